// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO transmitter.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } tx_state_t;

  localparam int DEFAULT_WIDTH = 6;

  // Callers zero-extend narrower words; the extra zeros do not change the XOR.
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/piso_6_bit_tx_shift_reg.sv
// Loadable shift register; o_bit is the flop holding the bit currently on the line.
module piso_shift_reg #(
  parameter int WIDTH     = 6,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_shift_en,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_sr;

  // Zeros shift in behind the word, so the line returns to 0 after the last bit.
  always_ff @(posedge clk) begin
    if (reset)           r_sr <= '0;
    else if (i_load)     r_sr <= i_data;
    else if (i_shift_en) r_sr <= MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
  end

  assign o_bit = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];

endmodule

// File: rtl/piso_6_bit_tx.sv
// Parallel-in serial-out transmitter with valid/ready input and back-to-back frames.
// Optional trailing even-parity bit enabled with `define PISO_PARITY_EN.
module piso_6_bit_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  tx_state_t        r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_ser_valid;
  logic             r_frame_start;

  logic             w_last_data;
  logic             w_end_cycle;
  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_load_data;

  assign w_last_data = (r_state == SHIFT) && (r_bit_cnt == LAST_CNT);

`ifdef PISO_PARITY_EN
  logic r_par;

  assign w_end_cycle = (r_state == PARITY);
  // On the last data bit the parity bit is loaded where the next bit would appear.
  assign w_load      = w_accept || w_last_data;
  assign w_load_data = w_accept ? in_data :
                       (MSB_FIRST ? {r_par, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, r_par});

  always_ff @(posedge clk) begin
    if (reset)         r_par <= 1'b0;
    else if (w_accept) r_par <= even_parity(32'(in_data));
  end
`else
  assign w_end_cycle = w_last_data;
  assign w_load      = w_accept;
  assign w_load_data = in_data;
`endif

  assign in_ready = !reset && ((r_state == IDLE) || w_end_cycle);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_ser_valid   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_accept;
      case (r_state)
        IDLE: if (w_accept) begin
          r_state     <= SHIFT;
          r_bit_cnt   <= '0;
          r_ser_valid <= 1'b1;
        end
        SHIFT: if (r_bit_cnt != LAST_CNT) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end else begin
`ifdef PISO_PARITY_EN
          r_state <= PARITY;
`else
          r_state     <= w_accept ? SHIFT : IDLE;
          r_bit_cnt   <= '0;
          r_ser_valid <= w_accept;
`endif
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          r_state     <= w_accept ? SHIFT : IDLE;
          r_bit_cnt   <= '0;
          r_ser_valid <= w_accept;
        end
`endif
        default: begin
          r_state     <= IDLE;
          r_bit_cnt   <= '0;
          r_ser_valid <= 1'b0;
        end
      endcase
    end
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_shift_en (!w_load),
    .i_data     (w_load_data),
    .o_bit      (ser_out)
  );

  assign ser_valid   = r_ser_valid;
  assign frame_start = r_frame_start;
  assign busy        = r_ser_valid;

endmodule

// File: tb/tb_piso_6_bit_tx.sv
// Directed bench for piso_6_bit_tx: one MSB-first and one LSB-first instance.
module tb_piso_6_bit_tx;

`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = PAR ? 7 : 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] in_data;
  logic       v_m, v_l;
  logic       rdy_m, so_m, sv_m, fs_m, bz_m;
  logic       rdy_l, so_l, sv_l, fs_l, bz_l;
  logic       sel;
  logic       rdy, so, sv, fs, bz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_6_bit_tx #(.WIDTH(6), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(v_m), .in_ready(rdy_m),
    .ser_out(so_m), .ser_valid(sv_m), .frame_start(fs_m), .busy(bz_m));

  piso_6_bit_tx #(.WIDTH(6), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(v_l), .in_ready(rdy_l),
    .ser_out(so_l), .ser_valid(sv_l), .frame_start(fs_l), .busy(bz_l));

  always_comb begin
    rdy = sel ? rdy_l : rdy_m;
    so  = sel ? so_l  : so_m;
    sv  = sel ? sv_l  : sv_m;
    fs  = sel ? fs_l  : fs_m;
    bz  = sel ? bz_l  : bz_m;
  end

  typedef struct {
    logic [5:0] data;
    logic       msb;
    logic [5:0] exp_seq;  // leftmost bit goes out first
    logic       exp_par;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Entered and left on a negedge; line is idle on entry.
  task automatic run_vec(input vec_t v, input int idx);
    sel = !v.msb;
    chk($sformatf("v%0d ready_idle", idx), {31'd0, rdy}, 32'd1);
    in_data = v.data;
    if (v.msb) v_m = 1'b1; else v_l = 1'b1;
    @(negedge clk);
    v_m = 1'b0; v_l = 1'b0;
    in_data = ~v.data;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("v%0d bit%0d", idx, k), {31'd0, so}, {31'd0, v.exp_seq[5-k]});
      chk($sformatf("v%0d valid%0d", idx, k), {31'd0, sv}, 32'd1);
      chk($sformatf("v%0d fs%0d", idx, k), {31'd0, fs}, (k == 0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d ready%0d", idx, k), {31'd0, rdy}, (k == 5 && !PAR) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    if (PAR) begin
      chk($sformatf("v%0d parity", idx), {31'd0, so}, {31'd0, v.exp_par});
      chk($sformatf("v%0d par_valid", idx), {31'd0, sv}, 32'd1);
      chk($sformatf("v%0d par_fs", idx), {31'd0, fs}, 32'd0);
      chk($sformatf("v%0d par_ready", idx), {31'd0, rdy}, 32'd1);
      @(negedge clk);
    end
    chk($sformatf("v%0d idle_valid", idx), {31'd0, sv}, 32'd0);
    chk($sformatf("v%0d idle_out", idx), {31'd0, so}, 32'd0);
    chk($sformatf("v%0d idle_busy", idx), {31'd0, bz}, 32'd0);
    chk($sformatf("v%0d idle_ready", idx), {31'd0, rdy}, 32'd1);
  endtask

  logic [13:0] b2b_exp;

  initial begin
    vecs[0] = '{data: 6'b101101, msb: 1'b1, exp_seq: 6'b101101, exp_par: 1'b0};
    vecs[1] = '{data: 6'b110010, msb: 1'b0, exp_seq: 6'b010011, exp_par: 1'b1};
    vecs[2] = '{data: 6'b000001, msb: 1'b1, exp_seq: 6'b000001, exp_par: 1'b1};
    vecs[3] = '{data: 6'b100000, msb: 1'b0, exp_seq: 6'b000001, exp_par: 1'b1};
    vecs[4] = '{data: 6'b111111, msb: 1'b1, exp_seq: 6'b111111, exp_par: 1'b0};
    vecs[5] = '{data: 6'b101100, msb: 1'b1, exp_seq: 6'b101100, exp_par: 1'b1};

    sel = 1'b0;
    reset = 1'b1; in_data = 6'h3F; v_m = 1'b1; v_l = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst%0d ready_m", c), {31'd0, rdy_m}, 32'd0);
      chk($sformatf("rst%0d ready_l", c), {31'd0, rdy_l}, 32'd0);
      chk($sformatf("rst%0d valid", c), {30'd0, sv_m, sv_l}, 32'd0);
      chk($sformatf("rst%0d out", c), {29'd0, so_m, so_l, fs_m}, 32'd0);
    end
    reset = 1'b0; v_m = 1'b0; v_l = 1'b0;
    #1;
    chk("rst_release ready", {30'd0, rdy_m, rdy_l}, 32'd3);
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Back-to-back: in_valid held high across the frame boundary.
    sel = 1'b0;
    b2b_exp = PAR ? 14'b1010101_0101011 : 14'b00_101010_010101;
    in_data = 6'h2A; v_m = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2 * FL; i++) begin
      chk($sformatf("b2b bit%0d", i), {31'd0, so}, {31'd0, b2b_exp[2*FL-1-i]});
      chk($sformatf("b2b valid%0d", i), {31'd0, sv}, 32'd1);
      chk($sformatf("b2b fs%0d", i), {31'd0, fs}, (i == 0 || i == FL) ? 32'd1 : 32'd0);
      if (i == FL - 1) chk("b2b ready_last", {31'd0, rdy}, 32'd1);
      if (i == 0) in_data = 6'h15;
      if (i == FL) v_m = 1'b0;
      @(negedge clk);
    end
    chk("b2b end_valid", {31'd0, sv}, 32'd0);
    chk("b2b end_out", {31'd0, so}, 32'd0);

    // Mid-frame reset after the third bit.
    in_data = 6'h3F; v_m = 1'b1;
    @(negedge clk);
    v_m = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mrst bit%0d", k), {30'd0, so, sv}, 32'd3);
      if (k < 2) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("mrst out", {29'd0, so, sv, fs}, 32'd0);
    chk("mrst busy", {31'd0, bz}, 32'd0);
    chk("mrst ready", {31'd0, rdy}, 32'd0);
    reset = 1'b0;
    #1;
    chk("mrst release ready", {31'd0, rdy}, 32'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("mrst residual%0d", c), {30'd0, so, sv}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
